mcu_rst_ctrl: RTL and testbench

Reset sequencer for the cm3_ahbmtx MCU. Merges all reset requesters into one prioritized reset event: power-on, watchdog, Cortex-M3 SYSRESETREQ, lockup and debug. Drives a staged, counted release of the APB1, system-bus and CPU reset domains inside `fp_domain`. Sits between the top-level reset pad logic and the `apb1_root_rstn` / `sys_root_rstn` inputs of the full-function domain.

---
 rtl/mcu_rst_pkg.sv | 19 +
 rtl/mcu_rst_ctrl.sv | 106 ++++++++++
 tb/tb_mcu_rst_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mcu_rst_pkg.sv
// Shared types and constants for the mcu_rst_ctrl reset sequencer.
// Reset-cause bit positions are used when MCU_RST_CAUSE_EN is defined.
package mcu_rst_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        REL_APB,
        REL_SYS,
        RUN
    } rst_state_e;

    localparam int unsigned RST_CAUSE_W      = 5;
    localparam int unsigned RST_CAUSE_POR    = 0;
    localparam int unsigned RST_CAUSE_WDT    = 1;
    localparam int unsigned RST_CAUSE_SYSREQ = 2;
    localparam int unsigned RST_CAUSE_LOCKUP = 3;
    localparam int unsigned RST_CAUSE_DBG    = 4;

endpackage

// File: rtl/mcu_rst_ctrl.sv
// Reset sequencer: merges reset requests and releases APB1, system bus and CPU in order.
// Optional sticky cause register enabled by defining MCU_RST_CAUSE_EN.
module mcu_rst_ctrl
    import mcu_rst_pkg::*;
#(
    parameter int unsigned PRE_CYCLES  = 16,
    parameter int unsigned STEP_CYCLES = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   sys_root_clk,
    input  logic                   sys_root_rst,
    input  logic                   wdt_rst_req,
    input  logic                   sysresetreq,
    input  logic                   lockup,
    input  logic                   lockup_rst_en,
    input  logic                   dbg_rst_req,
    output logic                   apb1_root_rstn,
    output logic                   sys_root_rstn,
    output logic                   cpu_rstn,
`ifdef MCU_RST_CAUSE_EN
    input  logic                   cause_clr,
    output logic [RST_CAUSE_W-1:0] rst_cause,
`endif
    output logic                   rst_busy
);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    rst_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lockup_req;
    logic             req;

    assign lockup_req = lockup & lockup_rst_en;
    assign req        = wdt_rst_req | sysresetreq | dbg_rst_req | lockup_req;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        if (req) begin
            state_nxt = ASSERT;
        end else begin
            unique case (state)
                ASSERT: begin
                    if (cnt == PRE_LAST) state_nxt = REL_APB;
                    else                 cnt_nxt   = cnt + 1'b1;
                end
                REL_APB: begin
                    if (cnt == STEP_LAST) state_nxt = REL_SYS;
                    else                  cnt_nxt   = cnt + 1'b1;
                end
                REL_SYS: begin
                    if (cnt == STEP_LAST) state_nxt = RUN;
                    else                  cnt_nxt   = cnt + 1'b1;
                end
                RUN: begin
                    state_nxt = RUN;
                end
                default: state_nxt = ASSERT;
            endcase
        end
    end

    // Outputs decode the next state so they switch on the same edge as the state register.
    always_ff @(posedge sys_root_clk) begin
        if (sys_root_rst) begin
            state          <= ASSERT;
            cnt            <= '0;
            apb1_root_rstn <= 1'b0;
            sys_root_rstn  <= 1'b0;
            cpu_rstn       <= 1'b0;
            rst_busy       <= 1'b1;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            apb1_root_rstn <= (state_nxt != ASSERT);
            sys_root_rstn  <= (state_nxt == REL_SYS) || (state_nxt == RUN);
            cpu_rstn       <= (state_nxt == RUN);
            rst_busy       <= (state_nxt != RUN);
        end
    end

`ifdef MCU_RST_CAUSE_EN
    logic [RST_CAUSE_W-1:0] cause_set;

    always_comb begin
        cause_set                   = '0;
        cause_set[RST_CAUSE_WDT]    = wdt_rst_req;
        cause_set[RST_CAUSE_SYSREQ] = sysresetreq;
        cause_set[RST_CAUSE_LOCKUP] = lockup_req;
        cause_set[RST_CAUSE_DBG]    = dbg_rst_req;
    end

    // Set has priority over clear for any bit whose source is active this cycle.
    always_ff @(posedge sys_root_clk) begin
        if (sys_root_rst) begin
            rst_cause                <= '0;
            rst_cause[RST_CAUSE_POR] <= 1'b1;
        end else begin
            rst_cause <= (cause_clr ? '0 : rst_cause) | cause_set;
        end
    end
`endif

endmodule

// File: tb/tb_mcu_rst_ctrl.sv
// Self-checking bench for mcu_rst_ctrl: directed scenarios plus randomized requests,
// compared against a quiet-cycle-count model of the release schedule.
module tb_mcu_rst_ctrl;

    localparam int unsigned PRE  = 16;
    localparam int unsigned STEP = 8;

    logic clk = 1'b0;
    logic rst, wdt, sreq, lck, lck_en, dbg;
    logic apb_n, sys_n, cpu_n, busy;
`ifdef MCU_RST_CAUSE_EN
    logic       clr;
    logic [4:0] cause;
    logic [4:0] m_cause;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int quiet       = 0;   // edges since the last reset or request, saturating

    always #5 clk = ~clk;

    mcu_rst_ctrl #(
        .PRE_CYCLES (PRE),
        .STEP_CYCLES(STEP),
        .CNT_W      (8)
    ) dut (
        .sys_root_clk  (clk),
        .sys_root_rst  (rst),
        .wdt_rst_req   (wdt),
        .sysresetreq   (sreq),
        .lockup        (lck),
        .lockup_rst_en (lck_en),
        .dbg_rst_req   (dbg),
        .apb1_root_rstn(apb_n),
        .sys_root_rstn (sys_n),
        .cpu_rstn      (cpu_n),
`ifdef MCU_RST_CAUSE_EN
        .cause_clr     (clr),
        .rst_cause     (cause),
`endif
        .rst_busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; wdt = 1'b0; sreq = 1'b0; lck = 1'b0; lck_en = 1'b0; dbg = 1'b0;
`ifdef MCU_RST_CAUSE_EN
        clr = 1'b0;
`endif
    endtask

    // One clock edge: update the model from the inputs seen at the edge, then compare.
    task automatic step();
        logic any_req;
        @(posedge clk);
        any_req = wdt | sreq | dbg | (lck & lck_en);
        if (rst || any_req) quiet = 0;
        else if (quiet < 1000) quiet++;
`ifdef MCU_RST_CAUSE_EN
        if (rst) m_cause = 5'b00001;
        else m_cause = (clr ? 5'b00000 : m_cause) | {dbg, lck & lck_en, sreq, wdt, 1'b0};
`endif
        #1;
        check("apb1_rstn", 32'(apb_n), 32'(quiet >= PRE));
        check("sys_rstn",  32'(sys_n), 32'(quiet >= PRE + STEP));
        check("cpu_rstn",  32'(cpu_n), 32'(quiet >= PRE + 2 * STEP));
        check("rst_busy",  32'(busy),  32'(quiet <  PRE + 2 * STEP));
`ifdef MCU_RST_CAUSE_EN
        check("rst_cause", 32'(cause), 32'(m_cause));
`endif
    endtask

    // Runs n idle edges and checks the edge index at which each domain is released.
    task automatic release_run(input string tag, input int n, input int apb_e, input int sys_e, input int cpu_e);
        int ra = 0, rs = 0, rc = 0;
        idle_inputs();
        for (int i = 1; i <= n; i++) begin
            step();
            if (apb_n && ra == 0) ra = i;
            if (sys_n && rs == 0) rs = i;
            if (cpu_n && rc == 0) rc = i;
        end
        check({tag, "_apb_edge"}, 32'(ra), 32'(apb_e));
        check({tag, "_sys_edge"}, 32'(rs), 32'(sys_e));
        check({tag, "_cpu_edge"}, 32'(rc), 32'(cpu_e));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
`ifdef MCU_RST_CAUSE_EN
        m_cause = 5'b00001;
`endif
        // Power-on reset: held three cycles, then a clean release.
        repeat (3) step();
        check("por_busy", 32'(busy), 32'd1);
`ifdef MCU_RST_CAUSE_EN
        check("por_cause", 32'(cause), 32'h01);
`endif
        release_run("por", 40, 16, 24, 32);

        // Single-cycle watchdog pulse while running.
        wdt = 1'b1;
        step();
        check("wdt_apb_now", 32'(apb_n), 32'd0);
        check("wdt_cpu_now", 32'(cpu_n), 32'd0);
        release_run("wdt", 40, 16, 24, 32);
`ifdef MCU_RST_CAUSE_EN
        check("wdt_cause", 32'(cause), 32'h03);
`endif

        // SYSRESETREQ at edge 20 of a POR sequence restarts it.
        rst = 1'b1;
        step();
        idle_inputs();
        for (int i = 1; i <= 19; i++) step();
        check("mid_apb_up", 32'(apb_n), 32'd1);
        sreq = 1'b1;
        step();
        check("mid_apb_down", 32'(apb_n), 32'd0);
        release_run("sreq", 40, 16, 24, 32);

        // Debug request held for 50 cycles stretches the reset.
        dbg = 1'b1;
        repeat (50) step();
        check("dbg_held_apb", 32'(apb_n), 32'd0);
        release_run("dbg", 40, 16, 24, 32);

        // Lockup is ignored unless enabled.
`ifdef MCU_RST_CAUSE_EN
        clr = 1'b1;
        step();
`endif
        idle_inputs();
        lck = 1'b1;
        repeat (5) step();
        check("lock_masked_cpu", 32'(cpu_n), 32'd1);
`ifdef MCU_RST_CAUSE_EN
        check("lock_masked_cause", 32'(cause[3]), 32'd0);
`endif
        lck_en = 1'b1;
        step();
        check("lock_en_cpu", 32'(cpu_n), 32'd0);
`ifdef MCU_RST_CAUSE_EN
        check("lock_en_cause", 32'(cause[3]), 32'd1);
`endif
        release_run("lock", 40, 16, 24, 32);

`ifdef MCU_RST_CAUSE_EN
        // Clear and watchdog together: the watchdog bit survives.
        clr = 1'b1;
        wdt = 1'b1;
        step();
        check("clr_wdt_cause", 32'(cause), 32'h02);
        idle_inputs();
        clr = 1'b1;
        step();
        check("clr_only_cause", 32'(cause), 32'h00);
        idle_inputs();
`endif

        // Randomized traffic: sparse requests so that full sequences still complete.
        for (int i = 0; i < 4000; i++) begin
            idle_inputs();
            rst    = ($urandom_range(0, 499) == 0);
            wdt    = ($urandom_range(0, 79) == 0);
            sreq   = ($urandom_range(0, 79) == 0);
            dbg    = ($urandom_range(0, 99) == 0);
            lck    = ($urandom_range(0, 9) == 0);
            lck_en = ($urandom_range(0, 7) == 0);
`ifdef MCU_RST_CAUSE_EN
            clr    = ($urandom_range(0, 15) == 0);
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
